// File: rtl/iso_stream_steering_if.sv
// Pixel-word input stream and steered per-lane byte output stream.
interface iso_stream_steering_if #(
    parameter int MAX_LANES   = 4,
    parameter int PIXEL_BYTES = 6
);
    logic [8*PIXEL_BYTES-1:0] in_data;
    logic                     in_valid;
    logic                     in_last;
    logic                     in_ready;
    logic [8*MAX_LANES-1:0]   steered_lane;
    logic [MAX_LANES-1:0]     steered_vld;
    logic                     steered_last;

    modport master (
        output in_data, in_valid, in_last,
        input  in_ready, steered_lane, steered_vld, steered_last
    );

    modport slave (
        input  in_data, in_valid, in_last,
        output in_ready, steered_lane, steered_vld, steered_last
    );
endinterface

// File: rtl/iso_stream_steering.sv
// Steers bytes of buffered pixel words onto 1, 2 or 4 link lanes per
// scheduler-enabled cycle, padding and flagging the final beat of a line.
module iso_stream_steering #(
    parameter int MAX_LANES   = 4,
    parameter int PIXEL_BYTES = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            td_lane_count,
    input  logic                  sched_steering_en,
    iso_stream_steering_if.slave  s
);
    localparam int DEPTH = 2 * PIXEL_BYTES;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int BW    = 8 * DEPTH;

    typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

    state_t                 state, state_nx;
    logic [CW-1:0]          cnt, cnt_nx, lanes, lanes_nx;
    logic [CW-1:0]          req_lanes, pop, base;
    logic [BW-1:0]          buf_q, buf_nx, buf_sh, ext;
    logic [8*MAX_LANES-1:0] lane_nx;
    logic [MAX_LANES-1:0]   vld_nx;
    logic                   last_nx, emit, push;

    assign s.in_ready = (state != FLUSH) && (cnt <= CW'(PIXEL_BYTES));
    assign push       = s.in_valid && s.in_ready;

    // Reserved encoding 10 falls back to a single lane.
    always_comb begin
        unique case (td_lane_count)
            2'b01:   req_lanes = CW'(2);
            2'b11:   req_lanes = CW'(4);
            default: req_lanes = CW'(1);
        endcase
        if (req_lanes > CW'(MAX_LANES)) req_lanes = CW'(MAX_LANES);
    end

    always_comb begin
        state_nx = state;
        lanes_nx = lanes;
        pop      = '0;
        emit     = 1'b0;
        last_nx  = 1'b0;
        lane_nx  = '0;
        vld_nx   = '0;
        unique case (state)
            IDLE: begin
                lanes_nx = req_lanes;
                if (push) state_nx = s.in_last ? FLUSH : STREAM;
            end
            STREAM: begin
                if (sched_steering_en && cnt >= lanes) begin
                    emit = 1'b1;
                    pop  = lanes;
                end
            end
            FLUSH: begin
                if (sched_steering_en && cnt != '0) begin
                    emit = 1'b1;
                    if (cnt <= lanes) begin
                        pop     = cnt;
                        last_nx = 1'b1;
                    end else begin
                        pop = lanes;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase

        cnt_nx = cnt - pop + (push ? CW'(PIXEL_BYTES) : CW'(0));

        if (state == STREAM) begin
            if (push && s.in_last)           state_nx = FLUSH;
            else if (!push && cnt_nx == '0)  state_nx = IDLE;
        end
        if (state == FLUSH && last_nx) state_nx = IDLE;

        // Bytes above cnt are always zero, so the final beat pads itself.
        for (int i = 0; i < MAX_LANES; i++) begin
            if (emit && i < int'(lanes)) begin
                vld_nx[i]         = 1'b1;
                lane_nx[8*i +: 8] = buf_q[8*i +: 8];
            end
        end

        buf_sh = buf_q >> {pop, 3'b000};
        base   = cnt - pop;
        ext    = BW'(s.in_data) << {base, 3'b000};
        buf_nx = push ? (buf_sh | ext) : buf_sh;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            lanes          <= CW'(1);
            buf_q          <= '0;
            s.steered_lane <= '0;
            s.steered_vld  <= '0;
            s.steered_last <= 1'b0;
        end else begin
            state          <= state_nx;
            cnt            <= cnt_nx;
            lanes          <= lanes_nx;
            buf_q          <= buf_nx;
            s.steered_lane <= lane_nx;
            s.steered_vld  <= vld_nx;
            s.steered_last <= last_nx;
        end
    end
endmodule

// File: tb/tb_iso_stream_steering.sv
// Directed and randomized checks of iso_stream_steering against a
// byte-queue model of the line steering rules.
module tb_iso_stream_steering;
    localparam int ML = 4;
    localparam int PB = 6;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] td_lane_count;
    logic       sched_steering_en;

    int checks = 0;
    int errors = 0;

    iso_stream_steering_if #(.MAX_LANES(ML), .PIXEL_BYTES(PB)) bus ();

    iso_stream_steering #(.MAX_LANES(ML), .PIXEL_BYTES(PB)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .td_lane_count     (td_lane_count),
        .sched_steering_en (sched_steering_en),
        .s                 (bus.slave)
    );

    always #5 clk = ~clk;

    logic [7:0] mq[$];
    bit         m_active;
    bit         m_flush;
    int         m_l;

    function automatic int lanes_of(input logic [1:0] t);
        int n;
        case (t)
            2'b01:   n = 2;
            2'b11:   n = 4;
            default: n = 1;
        endcase
        return (n > ML) ? ML : n;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_active = 0;
        m_flush  = 0;
        m_l      = 1;
    endtask

    task automatic step(input bit en, input bit v, input bit lst,
                        input logic [47:0] d, input logic [1:0] tdl,
                        output bit acc);
        logic [31:0] el;
        logic [3:0]  ev;
        bit          elast;
        bit          rdy;
        int          n;
        sched_steering_en = en;
        bus.in_valid      = v;
        bus.in_last       = lst;
        bus.in_data       = d;
        td_lane_count     = tdl;
        #1;
        rdy = !m_flush && (mq.size() <= PB);
        chk("in_ready", 64'(bus.in_ready), 64'(rdy));
        acc   = v && rdy;
        el    = '0;
        ev    = '0;
        elast = 0;
        n     = 0;
        if (!m_active) m_l = lanes_of(tdl);
        if (m_active && en) begin
            if (m_flush && mq.size() > 0 && mq.size() <= m_l) begin
                n        = mq.size();
                elast    = 1;
                m_active = 0;
                m_flush  = 0;
            end else if (mq.size() >= m_l) begin
                n = m_l;
            end
            if (n > 0)
                for (int i = 0; i < m_l; i++) ev[i] = 1'b1;
            for (int i = 0; i < n; i++) el[8*i +: 8] = mq.pop_front();
        end
        if (acc) begin
            for (int i = 0; i < PB; i++) mq.push_back(d[8*i +: 8]);
            m_active = 1;
            if (lst) m_flush = 1;
        end else if (m_active && !m_flush && mq.size() == 0) begin
            m_active = 0;
        end
        @(posedge clk);
        #1;
        chk("steered_lane", 64'(bus.steered_lane), 64'(el));
        chk("steered_vld", 64'(bus.steered_vld), 64'(ev));
        chk("steered_last", 64'(bus.steered_last), 64'(elast));
    endtask

    initial begin
        bit          acc;
        int          nw;
        int          t;
        logic [1:0]  tdl;
        logic [47:0] d;

        rst_n             = 1'b0;
        sched_steering_en = 1'b0;
        td_lane_count     = 2'b00;
        bus.in_valid      = 1'b0;
        bus.in_last       = 1'b0;
        bus.in_data       = '0;
        model_reset();
        #12;
        chk("rst_lane", 64'(bus.steered_lane), 64'h0);
        chk("rst_vld", 64'(bus.steered_vld), 64'h0);
        chk("rst_last", 64'(bus.steered_last), 64'h0);
        rst_n = 1'b1;
        #1;
        chk("rst_ready", 64'(bus.in_ready), 64'h1);

        // Two 4-lane words, second one last.
        step(1, 1, 0, 48'h060504030201, 2'b11, acc);
        step(1, 1, 1, 48'h0C0B0A090807, 2'b11, acc);
        chk("r24_beat1", 64'(bus.steered_lane), 64'h04030201);
        step(1, 0, 0, '0, 2'b11, acc);
        chk("r24_beat2", 64'(bus.steered_lane), 64'h08070605);
        step(1, 0, 0, '0, 2'b11, acc);
        chk("r24_beat3", 64'(bus.steered_lane), 64'h0C0B0A09);
        chk("r24_last", 64'(bus.steered_last), 64'h1);

        // Two lanes, single last word.
        step(1, 1, 1, 48'h060504030201, 2'b01, acc);
        for (int i = 0; i < 4; i++) step(1, 0, 0, '0, 2'b01, acc);

        // Four lanes, short last word padded with zeros.
        step(1, 1, 1, 48'h060504030201, 2'b11, acc);
        step(1, 0, 0, '0, 2'b11, acc);
        step(1, 0, 0, '0, 2'b11, acc);
        chk("r26_pad", 64'(bus.steered_lane), 64'h00000605);
        chk("r26_vld", 64'(bus.steered_vld), 64'hF);
        chk("r26_last", 64'(bus.steered_last), 64'h1);

        // Continuous words with toggling enable, lane count moved mid-line.
        for (int i = 0; i < 8; i++) begin
            d = {8'(12*i+6), 8'(12*i+5), 8'(12*i+4),
                 8'(12*i+3), 8'(12*i+2), 8'(12*i+1)};
            step(i % 2 == 0, 1, i == 7, d, (i < 2) ? 2'b11 : 2'b00, acc);
        end
        t = 0;
        while (m_active && t < 40) begin
            step(1, 0, 0, '0, 2'b00, acc);
            t++;
        end
        if (m_active) chk("drain_timeout", 64'h0, 64'h1);
        step(1, 1, 1, 48'h111111111111, 2'b00, acc);
        step(1, 0, 0, '0, 2'b00, acc);
        chk("r28_one_lane", 64'(bus.steered_vld), 64'h1);

        // Reset mid-line with five bytes buffered.
        t = 0;
        while (m_active && t < 20) begin
            step(1, 0, 0, '0, 2'b00, acc);
            t++;
        end
        step(1, 1, 0, 48'h060504030201, 2'b00, acc);
        step(1, 0, 0, '0, 2'b00, acc);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("r29_lane", 64'(bus.steered_lane), 64'h0);
        chk("r29_vld", 64'(bus.steered_vld), 64'h0);
        chk("r29_last", 64'(bus.steered_last), 64'h0);
        chk("r29_ready", 64'(bus.in_ready), 64'h1);
        #3;
        rst_n = 1'b1;
        step(1, 1, 1, 48'hAABBCCDDEEFF, 2'b01, acc);
        for (int i = 0; i < 3; i++) step(1, 0, 0, '0, 2'b01, acc);

        // Randomized lines.
        for (int ln = 0; ln < 30; ln++) begin
            nw  = $urandom_range(1, 4);
            tdl = 2'($urandom_range(0, 3));
            for (int w = 0; w < nw; w++) begin
                d   = {16'($urandom), $urandom};
                acc = 0;
                t   = 0;
                while (!acc && t < 60) begin
                    step($urandom_range(0, 3) != 0,
                         $urandom_range(0, 4) != 0,
                         w == nw - 1, d,
                         ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : tdl,
                         acc);
                    t++;
                end
                if (!acc) chk("accept_timeout", 64'h0, 64'h1);
            end
            t = 0;
            while (m_active && t < 80) begin
                step($urandom_range(0, 3) != 0, 0, 0, '0,
                     2'($urandom_range(0, 3)), acc);
                t++;
            end
            if (m_active) chk("drain_timeout", 64'h0, 64'h1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/iso_stream_steering.md
ISO_STREAM_STEERING -- requirements
Module: iso_stream_steering

Interface
REQ-001 SHALL have parameter MAX_LANES, default 4, max lanes steered; legal values 1, 2, 4.
REQ-002 SHALL have parameter PIXEL_BYTES, default 6, bytes per input word (6 = 48-bit pixel pair); legal when PIXEL_BYTES >= MAX_LANES.
REQ-003 SHALL have one clock and an asynchronous active-low reset: clk  in  1  link-symbol clock; rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have port td_lane_count  in  2  active lanes: 00=1, 01=2, 11=4, 10 reserved (treated as 1); values above MAX_LANES are clamped to MAX_LANES.
REQ-005 SHALL have port sched_steering_en  in  1  scheduler permission to emit stream bytes this cycle.
REQ-006 SHALL have port in_data  in  8*PIXEL_BYTES  pixel word; byte 0 = bits [7:0], sent first.
REQ-007 SHALL have ports in_valid  in  1  word offered; in_last  in  1  word is last of the line; in_ready  out  1  word accepted when in_valid && in_ready.
REQ-008 SHALL have port steered_lane  out  8*MAX_LANES  byte for lane i at bits [8i+7:8i].
REQ-009 SHALL have ports steered_vld  out  MAX_LANES  per-lane byte valid; steered_last  out  1  final beat of the line.

Function
REQ-010 SHALL hold a byte buffer of 2*PIXEL_BYTES bytes with occupancy count cnt (width clog2(2*PIXEL_BYTES+1)).
REQ-011 SHALL drive in_ready = (state != FLUSH) && (cnt <= PIXEL_BYTES), combinational from registered state only.
REQ-012 SHALL use an FSM with states IDLE, STREAM, FLUSH.
REQ-013 IDLE: cnt==0; active lane count L latched from td_lane_count each cycle; on word accept -> STREAM (in_last=1 -> FLUSH).
REQ-014 STREAM: when sched_steering_en && cnt >= L, pop L bytes (buffer bytes 0..L-1 to lanes 0..L-1); on accept with in_last=1 -> FLUSH; when cnt reaches 0 with no accept -> IDLE.
REQ-015 FLUSH: no accepts; pop L bytes per enabled cycle; when 0 < cnt <= L, emit remaining bytes, pad remaining active lanes with 0x00, assert steered_last, -> IDLE.
REQ-016 Simultaneous push and pop in one cycle: cnt_next = cnt - pop + PIXEL_BYTES, pushed bytes appended after the remaining bytes in order; no byte lost or duplicated.
REQ-017 Outputs SHALL be registered: a word accepted in cycle N with cnt==0 and L <= PIXEL_BYTES produces its first beat in cycle N+1 (requires sched_steering_en in N+1).
REQ-018 steered_vld[i] = 1 for i < L on an emit beat, 0 otherwise; steered_lane bytes for lanes >= L and on non-emit cycles SHALL be 0x00.
REQ-019 sched_steering_en=0 SHALL pause emission (vld=0, data 0) with buffer, cnt, and state held; accepts continue while in_ready.
REQ-020 td_lane_count changes outside IDLE SHALL be ignored until the next return to IDLE.
REQ-021 steered_last SHALL be asserted only on the beat carrying the final byte of an in_last word, including when cnt == L exactly (no pad).

Reset
REQ-022 On rst_n low, asynchronously: state=IDLE, cnt=0, L=1, buffer cleared, steered_lane=0, steered_vld=0, steered_last=0; in_ready=1 after release.
REQ-023 Reset asserted mid-line SHALL discard buffered bytes; no steered_last is generated for the aborted line.

Verification
REQ-024 4 lanes, en=1, two words 0x060504030201 then 0x0C0B0A090807 (last) -> beats 01,02,03,04 / 05,06,07,08 / 09,0A,0B,0C with steered_last on beat 3.
REQ-025 2 lanes, one word 0x060504030201 last -> beats 01,02 / 03,04 / 05,06 last; in_ready low from accept until IDLE.
REQ-026 4 lanes, one word 0x060504030201 last -> beats 01..04 then 05,06,00,00 with vld=1111 and steered_last=1.
REQ-027 Continuous words, en toggled 1,0,1,0 -> byte order preserved, in_ready drops when cnt > 6, no byte lost.
REQ-028 td_lane_count changed 11->00 mid-line -> remaining line stays 4-lane; next line uses 1 lane.
REQ-029 rst_n pulsed low with cnt=5 -> all outputs 0 immediately; cnt=0, state IDLE; next line starts clean.
